mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 29 ++
 rtl/bus_watchdog.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared memory-system types: arbiter and miss-controller state codes
package mem_bus_arbiter_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_W    = 32;
    localparam int WDOG_W    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GNT_I = 3'd1,
        GNT_D = 3'd2,
        TURN  = 3'd3,
        ERR   = 3'd4
    } arb_state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } arb_side_t;

    typedef enum logic [2:0] {
        MISS_IDLE  = 3'd0,
        MISS_REQ   = 3'd1,
        MISS_FILL  = 3'd2,
        MISS_WB    = 3'd3,
        MISS_DONE  = 3'd4
    } miss_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - reusable bus-master watchdog; expired flags the cycle the count would reach LIMIT
module bus_watchdog #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // Expiry is judged on the incrementing cycle so a same-cycle ack (which drops count_en) wins.
    assign expired = count_en && (count == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master (I/D miss controller) memory bus arbiter with timeout watchdog
module mem_bus_arbiter #(
    parameter int WORD_SIZE      = mem_bus_arbiter_pkg::WORD_SIZE,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          i_addr,
    input  logic                 i_re,
    input  logic                 i_wr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic [31:0]          d_addr,
    input  logic                 d_re,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic [31:0]          mem_addr,
    output logic                 mem_re,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 bus_err
);

    import mem_bus_arbiter_pkg::*;

    arb_state_t state, state_next;
    arb_side_t  last;

    logic i_req, d_req, gnt_i, gnt_d, granting;
    logic wd_clear, wd_count_en, wd_expired;

    assign i_req    = i_re | i_wr;
    assign d_req    = d_re | d_wr;
    assign gnt_i    = (state == GNT_I);
    assign gnt_d    = (state == GNT_D);
    assign granting = (state == IDLE) && (state_next == GNT_I || state_next == GNT_D);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || last == LAST_I)) state_next = GNT_D;
                else if (i_req)                          state_next = GNT_I;
            end
            GNT_I: begin
                if (!i_req)          state_next = TURN;
                else if (wd_expired) state_next = ERR;
            end
            GNT_D: begin
                if (!d_req)          state_next = TURN;
                else if (wd_expired) state_next = ERR;
            end
            TURN:    state_next = IDLE;
            // last still names the side that timed out
            ERR: begin
                if ((last == LAST_I) ? !i_req : !d_req) state_next = TURN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= LAST_I;
            bus_err <= 1'b0;
        end else begin
            state <= state_next;
            if (granting) last <= (state_next == GNT_D) ? LAST_D : LAST_I;
            if ((gnt_i || gnt_d) && state_next == ERR) bus_err <= 1'b1;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        if (gnt_i) begin
            mem_addr  = i_addr;
            mem_re    = i_re;
            mem_wr    = i_wr;
            mem_wdata = i_wdata;
        end else if (gnt_d) begin
            mem_addr  = d_addr;
            mem_re    = d_re;
            mem_wr    = d_wr;
            mem_wdata = d_wdata;
        end
    end

    assign i_ack   = mem_ack & gnt_i;
    assign d_ack   = mem_ack & gnt_d;
    assign i_rdata = gnt_i ? mem_rdata : '0;
    assign d_rdata = gnt_d ? mem_rdata : '0;

    assign wd_clear    = granting | mem_ack;
    assign wd_count_en = (gnt_i | gnt_d) & (mem_re | mem_wr) & ~mem_ack;

    bus_watchdog #(
        .WIDTH (WDOG_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_addr, d_addr, mem_addr;
    logic        i_re, i_wr, d_re, d_wr;
    logic [31:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic        i_ack, d_ack;
    logic        mem_re, mem_wr, mem_ack, bus_err;
    logic [31:0] mem_wdata, mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        side;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_re(i_re), .i_wr(i_wr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ack(i_ack),
        .d_addr(d_addr), .d_re(d_re), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input arb_state_t exp);
        check(name, 32'(dut.state), 32'(exp));
    endtask

    // side: 1 = D, 0 = I
    task automatic ack_word(input logic side, input logic [31:0] data, input logic [31:0] addr);
        mem_ack   = 1'b1;
        mem_rdata = data;
        sb.push_back('{side, data, addr});
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_re = 0; i_wr = 0; d_re = 0; d_wr = 0;
        mem_ack = 0; mem_rdata = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (i_ack || d_ack)) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'b0, i_ack, d_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_side", {30'b0, i_ack, d_ack}, e.side ? 32'd1 : 32'd2);
                check("ack_rdata", e.side ? d_rdata : i_rdata, e.data);
                check("ack_other_rdata", e.side ? i_rdata : d_rdata, 32'd0);
                check("ack_addr", mem_addr, e.addr);
            end
        end
    end

    initial begin
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
        i_re = 0; i_wr = 0; d_re = 0; d_wr = 0;
        mem_ack = 0; mem_rdata = '0;
        rst_n = 1'b0;
        #2;
        check("rst_mem_re", {31'b0, mem_re}, 0);
        check("rst_mem_wr", {31'b0, mem_wr}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_bus_err", {31'b0, bus_err}, 0);
        check("rst_acks", {30'b0, i_ack, d_ack}, 0);
        check_state("rst_state", IDLE);
        cyc();
        cyc();
        rst_n = 1'b1;

        // single D read, 16 words
        d_re = 1; d_addr = 32'h40;
        #1 check("s1_no_strobe_in_idle", {31'b0, mem_re}, 0);
        cyc();
        check_state("s1_gnt_d", GNT_D);
        check("s1_mem_re", {31'b0, mem_re}, 1);
        check("s1_mem_addr", mem_addr, 32'h40);
        for (int w = 0; w < 16; w++) begin
            d_addr = 32'h40 + 32'(w) * 4;
            ack_word(1'b1, 32'hC0DE_0000 + 32'(w), 32'h40 + 32'(w) * 4);
        end
        d_re = 0;
        #1 check("s1_strobe_drops", {31'b0, mem_re}, 0);
        cyc();
        check_state("s1_turn", TURN);
        cyc();
        check_state("s1_idle", IDLE);

        // tie after reset: D first, then I
        do_reset();
        i_re = 1; i_addr = 32'h100; d_re = 1; d_addr = 32'h200;
        cyc();
        check_state("s2_gnt_d_first", GNT_D);
        check("s2_addr_d", mem_addr, 32'h200);
        ack_word(1'b1, 32'hD2D2_0001, 32'h200);
        d_re = 0;
        cyc();
        check_state("s2_turn", TURN);
        mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        cyc();
        mem_ack = 0; mem_rdata = '0;
        check_state("s2_idle", IDLE);
        cyc();
        check_state("s2_gnt_i", GNT_I);
        check("s2_addr_i", mem_addr, 32'h100);
        ack_word(1'b0, 32'h1111_0002, 32'h100);
        i_re = 0;
        cyc();
        cyc();

        // alternation D,I,D,I
        i_addr = 32'h300; d_addr = 32'h400; i_re = 1; d_re = 1;
        for (int t = 0; t < 4; t++) begin
            int n;
            logic side;
            side = (t % 2 == 0);
            n = 0;
            cyc();
            while (dut.state != GNT_I && dut.state != GNT_D && n < 10) begin
                cyc();
                n++;
            end
            check("s3_grant_wait", 32'(n < 10), 32'd1);
            check_state("s3_order", side ? GNT_D : GNT_I);
            ack_word(side, 32'hA1A0_0000 + 32'(t), side ? 32'h400 : 32'h300);
            if (side) d_re = 0; else i_re = 0;
            cyc();
            if (side) d_re = 1; else i_re = 1;
        end
        i_re = 0; d_re = 0;
        cyc(); cyc(); cyc();

        // timeout on an I write
        i_wr = 1; i_addr = 32'h500; i_wdata = 32'hDEAD_BEEF;
        cyc();
        check("s4_mem_wr", {31'b0, mem_wr}, 1);
        check("s4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        repeat (254) cyc();
        check_state("s4_still_gnt_at_255", GNT_I);
        check("s4_no_err_yet", {31'b0, bus_err}, 0);
        cyc();
        check_state("s4_err", ERR);
        check("s4_bus_err", {31'b0, bus_err}, 1);
        check("s4_mem_wr_off", {31'b0, mem_wr}, 0);
        check("s4_mem_addr_off", mem_addr, 0);
        mem_ack = 1;
        cyc();
        mem_ack = 0;
        check_state("s4_err_held", ERR);
        i_wr = 0;
        cyc();
        check_state("s4_turn", TURN);
        check("s4_err_sticky_turn", {31'b0, bus_err}, 1);
        cyc();
        check_state("s4_idle", IDLE);
        check("s4_err_sticky_idle", {31'b0, bus_err}, 1);

        // boundary: ack on cycle 255 wins
        do_reset();
        check("s5_reset_clears_err", {31'b0, bus_err}, 0);
        i_re = 1; i_addr = 32'h600;
        cyc();
        repeat (254) cyc();
        ack_word(1'b0, 32'h5555_00FF, 32'h600);
        check_state("s5_no_err_state", GNT_I);
        check("s5_no_err_flag", {31'b0, bus_err}, 0);
        repeat (254) cyc();
        check_state("s5_counter_cleared", GNT_I);
        check("s5_counter_cleared_flag", {31'b0, bus_err}, 0);
        i_re = 0;
        cyc();
        check_state("s5_turn", TURN);
        check("s5_final_no_err", {31'b0, bus_err}, 0);
        cyc();

        // reset during word 5 of a D read
        d_re = 1; d_addr = 32'h700;
        cyc();
        for (int w = 0; w < 5; w++) ack_word(1'b1, 32'h6000_0000 + 32'(w), 32'h700);
        mem_ack = 1; mem_rdata = 32'h6000_0005;
        rst_n = 0;
        #1;
        check("s6_mem_re", {31'b0, mem_re}, 0);
        check("s6_mem_addr", mem_addr, 0);
        check("s6_d_ack", {31'b0, d_ack}, 0);
        check("s6_d_rdata", d_rdata, 0);
        check_state("s6_state", IDLE);
        cyc();
        mem_ack = 0; mem_rdata = '0;
        rst_n = 1;
        #1 check_state("s6_idle_after_release", IDLE);
        cyc();
        check_state("s6_resume", GNT_D);
        d_re = 0;
        cyc(); cyc(); cyc();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
